// File: rtl/vend_fsm_param.sv
// vend_fsm_param: parametrised coin vending controller.
// Accumulates credit in 5 tk units, vends at PRICE_UNITS and returns any excess as change.
// Change and refunds are handed to the dispenser through a chg_valid/chg_ack handshake.
// Optional build macro VEND_TIMEOUT_EN: after TIMEOUT_CYC idle cycles in COLLECT, the
// controller refunds automatically, exactly as if cancel had been pressed.
module vend_fsm_param #(
  parameter int unsigned PRICE_UNITS = 3,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          mny,
  input  logic                cancel,
  input  logic                chg_ack,
  output logic                buy,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state,
  output logic                coin_reject
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE_UNITS);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);

  state_t            cur;
  logic [CREDIT_W:0] coin_val;
  logic [CREDIT_W:0] sum;
  logic              timeout;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  assign timeout = (idle_cnt == TW'(TIMEOUT_CYC));
`else
  assign timeout = 1'b0;
`endif

  assign state = cur;

  // Decode the coin code and form the one-bit-wider sum whose MSB flags overflow.
  always_comb begin
    coin_val = '0;
    case (mny)
      2'b01:   coin_val = (CREDIT_W+1)'(2);
      2'b10:   coin_val = (CREDIT_W+1)'(4);
      2'b11:   coin_val = (CREDIT_W+1)'(10);
      default: coin_val = '0;
    endcase
    sum = {1'b0, credit} + coin_val;
  end

  // Controller state, credit bookkeeping and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      buy         <= 1'b0;
      chg_valid   <= 1'b0;
      chg_amt     <= '0;
      credit      <= '0;
      coin_reject <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      buy         <= 1'b0;
      coin_reject <= 1'b0;
      case (cur)
        IDLE: begin
          if (mny != 2'b00) begin
            credit <= coin_val[CREDIT_W-1:0];
`ifdef VEND_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (coin_val >= PRICE_W) begin
              cur <= VEND;
              buy <= 1'b1;
            end else begin
              cur <= COLLECT;
            end
          end
        end
        COLLECT: begin
          // Timeout shares the cancel path so both produce the identical refund.
          if (cancel || timeout) begin
            chg_amt     <= credit;
            credit      <= '0;
            chg_valid   <= 1'b1;
            cur         <= CHANGE;
            coin_reject <= (mny != 2'b00);
          end else if (mny != 2'b00) begin
            if (sum[CREDIT_W]) begin
              coin_reject <= 1'b1;
`ifdef VEND_TIMEOUT_EN
              idle_cnt    <= idle_cnt + TW'(1);
`endif
            end else begin
              credit <= sum[CREDIT_W-1:0];
`ifdef VEND_TIMEOUT_EN
              idle_cnt <= '0;
`endif
              if (sum >= PRICE_W) begin
                cur <= VEND;
                buy <= 1'b1;
              end
            end
          end else begin
`ifdef VEND_TIMEOUT_EN
            idle_cnt <= idle_cnt + TW'(1);
`endif
          end
        end
        VEND: begin
          coin_reject <= (mny != 2'b00);
          chg_amt     <= credit - PRICE_C;
          credit      <= '0;
          if (credit > PRICE_C) begin
            chg_valid <= 1'b1;
            cur       <= CHANGE;
          end else begin
            cur       <= IDLE;
          end
        end
        CHANGE: begin
          coin_reject <= (mny != 2'b00);
          if (chg_ack) begin
            chg_valid <= 1'b0;
            chg_amt   <= '0;
            cur       <= IDLE;
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// tb_vend_fsm_param: directed checks of the vending controller at the default parameters
// and at a narrow, high-price configuration that exposes the credit overflow reject.
module tb_vend_fsm_param;

  logic       clock;
  logic       reset;

  logic [1:0] mny;
  logic       cancel;
  logic       chg_ack;
  logic       buy;
  logic       chg_valid;
  logic [5:0] chg_amt;
  logic [5:0] credit;
  logic [1:0] state;
  logic       coin_reject;

  logic [1:0] mny_b;
  logic       cancel_b;
  logic       chg_ack_b;
  logic       buy_b;
  logic       chg_valid_b;
  logic [3:0] chg_amt_b;
  logic [3:0] credit_b;
  logic [1:0] state_b;
  logic       coin_reject_b;

  int unsigned checks;
  int unsigned errors;

  vend_fsm_param u_dut (
    .clock       (clock),
    .reset       (reset),
    .mny         (mny),
    .cancel      (cancel),
    .chg_ack     (chg_ack),
    .buy         (buy),
    .chg_valid   (chg_valid),
    .chg_amt     (chg_amt),
    .credit      (credit),
    .state       (state),
    .coin_reject (coin_reject)
  );

  vend_fsm_param #(
    .PRICE_UNITS (12),
    .CREDIT_W    (4),
    .TIMEOUT_CYC (16)
  ) u_dut_b (
    .clock       (clock),
    .reset       (reset),
    .mny         (mny_b),
    .cancel      (cancel_b),
    .chg_ack     (chg_ack_b),
    .buy         (buy_b),
    .chg_valid   (chg_valid_b),
    .chg_amt     (chg_amt_b),
    .credit      (credit_b),
    .state       (state_b),
    .coin_reject (coin_reject_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    mny       = 2'b00;
    cancel    = 1'b0;
    chg_ack   = 1'b0;
    mny_b     = 2'b00;
    cancel_b  = 1'b0;
    chg_ack_b = 1'b0;

    #12;
    check("rst_state", state, 0);
    check("rst_buy", buy, 0);
    check("rst_chg_valid", chg_valid, 0);
    check("rst_chg_amt", chg_amt, 0);
    check("rst_credit", credit, 0);
    check("rst_reject", coin_reject, 0);
    reset = 1'b0;
    tick();

    // 20 tk from idle: vend, then 1 unit change held until acknowledged
    mny = 2'b10; tick(); mny = 2'b00;
    check("t1_buy", buy, 1);
    check("t1_state_vend", state, 2);
    tick();
    check("t1_state_chg", state, 3);
    check("t1_chg_valid", chg_valid, 1);
    check("t1_chg_amt", chg_amt, 1);
    check("t1_buy_low", buy, 0);
    check("t1_credit0", credit, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_chg_hold", chg_amt, 1);
    end
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    check("t1_idle", state, 0);
    check("t1_valid_low", chg_valid, 0);
    check("t1_amt_clr", chg_amt, 0);

    // two 10 tk coins: credit 2 then vend with 1 unit change
    mny = 2'b01; tick();
    check("t2_credit2", credit, 2);
    check("t2_collect", state, 1);
    mny = 2'b01; tick(); mny = 2'b00;
    check("t2_buy", buy, 1);
    check("t2_credit4", credit, 4);
    tick();
    check("t2_chg_amt", chg_amt, 1);
    check("t2_state_chg", state, 3);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    mny = 2'b01; tick(); mny = 2'b00; tick();
    check("t2_hold_state", state, 1);
    check("t2_hold_credit", credit, 2);
    check("t2_no_buy", buy, 0);
    // cancel in IDLE is ignored; first clear this credit with a cancel in COLLECT
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("t2_cancel_amt", chg_amt, 2);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("idle_cancel_noop", state, 0);

    // cancel with a coin in the same cycle rejects the coin and refunds 2
    mny = 2'b01; tick();
    cancel = 1'b1; mny = 2'b10; tick(); cancel = 1'b0; mny = 2'b00;
    check("t3_reject", coin_reject, 1);
    check("t3_chg_amt", chg_amt, 2);
    check("t3_no_buy", buy, 0);
    check("t3_credit0", credit, 0);
    check("t3_state", state, 3);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    check("t3_idle", state, 0);

    // 50 tk: change 7, then asynchronous reset mid-cycle discards it
    mny = 2'b11; tick(); mny = 2'b00;
    check("t5_buy", buy, 1);
    check("t5_credit10", credit, 10);
    tick();
    check("t5_chg_amt7", chg_amt, 7);
    #3 reset = 1'b1;
    #1;
    check("t5_rst_state", state, 0);
    check("t5_rst_amt", chg_amt, 0);
    check("t5_rst_valid", chg_valid, 0);
    reset = 1'b0;
    tick();
    mny = 2'b10; tick();
    check("t5_vend", state, 2);
    tick(); mny = 2'b00;
    check("t5_vend_reject", coin_reject, 1);
    check("t5_vend_chg", chg_amt, 1);
    mny = 2'b11; tick(); mny = 2'b00;
    check("t5_chg_reject", coin_reject, 1);
    check("t5_chg_stable", chg_amt, 1);
    tick();
    check("t5_reject_1cyc", coin_reject, 0);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;

    // narrow build: 10+10 overflows 4 bits and is rejected, 10+2 vends exactly
    mny_b = 2'b11; tick();
    check("t4_credit10", credit_b, 10);
    check("t4_collect", state_b, 1);
    mny_b = 2'b11; tick();
    check("t4_reject", coin_reject_b, 1);
    check("t4_credit_kept", credit_b, 10);
    check("t4_still_collect", state_b, 1);
    mny_b = 2'b01; tick(); mny_b = 2'b00;
    check("t4_buy", buy_b, 1);
    check("t4_credit12", credit_b, 12);
    tick();
    check("t4_idle", state_b, 0);
    check("t4_no_chg", chg_amt_b, 0);
    check("t4_no_valid", chg_valid_b, 0);

`ifdef VEND_TIMEOUT_EN
    // credit 2, coin after 9 idle cycles restarts the count, then timeout refunds 4
    mny_b = 2'b01; tick(); mny_b = 2'b00;
    repeat (9) tick();
    mny_b = 2'b01; tick(); mny_b = 2'b00;
    repeat (16) tick();
    check("t6_restart_collect", state_b, 1);
    tick();
    check("t6_timeout_state", state_b, 3);
    check("t6_timeout_amt", chg_amt_b, 4);
    chg_ack_b = 1'b1; tick(); chg_ack_b = 1'b0;
`else
    // without the timeout, credit is held in COLLECT indefinitely
    mny = 2'b01; tick(); mny = 2'b00;
    repeat (100) tick();
    check("t6_no_timeout", state, 1);
    check("t6_credit_held", credit, 2);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
`endif
    check("end_idle", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
